// File: rtl/control_unit.sv
// control_unit: opcode decoder for the 8-bit CPU.
// Maps opcode and zero_flag to ALU select, immediate select, register write
// enable and PC jump enable. All outputs are registered, so they follow the
// sampled instruction by one clock. A HLT instruction latches a sticky halted
// state. From then on every opcode decodes as NOP until rst is asserted.
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       zero_flag,
    output logic [3:0] alu_op,
    output logic       use_immediate,
    output logic       write_enable,
    output logic       jmp_enable
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b0110;
    localparam logic [3:0] OP_SHL  = 4'b0111;
    localparam logic [3:0] OP_SHR  = 4'b1000;
    localparam logic [3:0] OP_ADDI = 4'b1001;
    localparam logic [3:0] OP_SUBI = 4'b1010;
    localparam logic [3:0] OP_LDI  = 4'b1011;
    localparam logic [3:0] OP_JZ   = 4'b1100;
    localparam logic [3:0] OP_JNZ  = 4'b1101;
    localparam logic [3:0] OP_JMP  = 4'b1110;
    localparam logic [3:0] OP_HLT  = 4'b1111;

    // ALU function codes. ALU_PASSB forwards operand B for LDI.
    localparam logic [3:0] ALU_NONE  = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0001;
    localparam logic [3:0] ALU_SUB   = 4'b0010;
    localparam logic [3:0] ALU_PASSB = 4'b1001;

    state_t     state_r;
    state_t     state_next_s;

    logic [3:0] alu_op_s;
    logic       use_immediate_s;
    logic       write_enable_s;
    logic       jmp_enable_s;

    // Halt-state register: rst is the only way to leave the halted state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: enter the halted state when HLT is sampled while running.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (opcode == OP_HLT) begin
                    state_next_s = ST_HALTED;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALTED: state_next_s = ST_HALTED;
            default:   state_next_s = ST_RUN;
        endcase
    end

    // Output decode: the opcode table, forced to NOP while halted.
    always_comb begin
        alu_op_s        = ALU_NONE;
        use_immediate_s = 1'b0;
        write_enable_s  = 1'b0;
        jmp_enable_s    = 1'b0;
        if (state_r == ST_HALTED) begin
            alu_op_s        = ALU_NONE;
            use_immediate_s = 1'b0;
            write_enable_s  = 1'b0;
            jmp_enable_s    = 1'b0;
        end else begin
            case (opcode)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                OP_NOT, OP_SHL, OP_SHR: begin
                    // Register-register ops: ALU code equals the opcode.
                    alu_op_s       = opcode;
                    write_enable_s = 1'b1;
                end
                OP_ADDI: begin
                    alu_op_s        = ALU_ADD;
                    use_immediate_s = 1'b1;
                    write_enable_s  = 1'b1;
                end
                OP_SUBI: begin
                    alu_op_s        = ALU_SUB;
                    use_immediate_s = 1'b1;
                    write_enable_s  = 1'b1;
                end
                OP_LDI: begin
                    alu_op_s        = ALU_PASSB;
                    use_immediate_s = 1'b1;
                    write_enable_s  = 1'b1;
                end
                OP_JZ: begin
                    use_immediate_s = 1'b1;
                    jmp_enable_s    = zero_flag;
                end
                OP_JNZ: begin
                    use_immediate_s = 1'b1;
                    jmp_enable_s    = ~zero_flag;
                end
                OP_JMP: begin
                    use_immediate_s = 1'b1;
                    jmp_enable_s    = 1'b1;
                end
                OP_NOP, OP_HLT: begin
                    alu_op_s = ALU_NONE;
                end
                default: begin
                    alu_op_s = ALU_NONE;
                end
            endcase
        end
    end

    // Output registers: one cycle of decode latency, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_op        <= 4'b0000;
            use_immediate <= 1'b0;
            write_enable  <= 1'b0;
            jmp_enable    <= 1'b0;
        end else begin
            alu_op        <= alu_op_s;
            use_immediate <= use_immediate_s;
            write_enable  <= write_enable_s;
            jmp_enable    <= jmp_enable_s;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed-vector bench for control_unit.
// Observed and expected values are packed as {alu_op, use_immediate, write_enable, jmp_enable}.
`timescale 1ns/1ps
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic       zero_flag;
    logic [3:0] alu_op;
    logic       use_immediate;
    logic       write_enable;
    logic       jmp_enable;

    int n_vec;
    int n_miss;

    control_unit dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .zero_flag     (zero_flag),
        .alu_op        (alu_op),
        .use_immediate (use_immediate),
        .write_enable  (write_enable),
        .jmp_enable    (jmp_enable)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] outs_now();
        return {alu_op, use_immediate, write_enable, jmp_enable};
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
        n_vec = n_vec + 1;
        if (obs !== exp_v) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got alu=%b imm=%b we=%b jmp=%b, want alu=%b imm=%b we=%b jmp=%b",
                     tag, obs[6:3], obs[2], obs[1], obs[0],
                     exp_v[6:3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    // Drive one instruction at the falling edge, then sample 1 ns after the next rising edge.
    task automatic apply(input string tag, input logic [3:0] op, input logic z,
                         input logic [6:0] exp_v);
        @(negedge clk);
        opcode    = op;
        zero_flag = z;
        @(posedge clk);
        #1;
        chk(tag, outs_now(), exp_v);
    endtask

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        rst       = 1'b1;
        opcode    = 4'b0001;
        zero_flag = 1'b0;

        #2;
        chk("reset_held", outs_now(), 7'b0000_0_0_0);
        @(posedge clk);
        #1;
        chk("reset_held_edge", outs_now(), 7'b0000_0_0_0);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("add_after_reset", outs_now(), 7'b0001_0_1_0);

        // Asynchronous clear: assert rst mid-cycle and check before the next edge.
        #1;
        rst = 1'b1;
        #1;
        chk("async_clear", outs_now(), 7'b0000_0_0_0);
        @(negedge clk);
        rst = 1'b0;

        apply("not",      4'b0110, 1'b0, 7'b0110_0_1_0);
        apply("xor",      4'b0101, 1'b0, 7'b0101_0_1_0);
        apply("shr",      4'b1000, 1'b1, 7'b1000_0_1_0);
        apply("jmp_z0",   4'b1110, 1'b0, 7'b0000_1_0_1);
        apply("jmp_z1",   4'b1110, 1'b1, 7'b0000_1_0_1);
        apply("jz_z1",    4'b1100, 1'b1, 7'b0000_1_0_1);
        apply("jz_z0",    4'b1100, 1'b0, 7'b0000_1_0_0);
        apply("jnz_z1",   4'b1101, 1'b1, 7'b0000_1_0_0);
        apply("jnz_z0",   4'b1101, 1'b0, 7'b0000_1_0_1);
        apply("addi",     4'b1001, 1'b0, 7'b0001_1_1_0);
        apply("subi",     4'b1010, 1'b1, 7'b0010_1_1_0);
        apply("ldi",      4'b1011, 1'b0, 7'b1001_1_1_0);
        apply("sub_z1",   4'b0010, 1'b1, 7'b0010_0_1_0);
        apply("nop",      4'b0000, 1'b1, 7'b0000_0_0_0);
        apply("add",      4'b0001, 1'b0, 7'b0001_0_1_0);
        apply("hlt",      4'b1111, 1'b0, 7'b0000_0_0_0);
        apply("halt_add", 4'b0001, 1'b0, 7'b0000_0_0_0);
        apply("halt_jmp", 4'b1110, 1'b1, 7'b0000_0_0_0);
        apply("halt_ldi", 4'b1011, 1'b0, 7'b0000_0_0_0);

        // Pulse rst to leave the halted state, then ADD decodes again.
        @(negedge clk);
        opcode = 4'b0001;
        rst    = 1'b1;
        #1;
        chk("halt_rst_clear", outs_now(), 7'b0000_0_0_0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("add_after_halt_rst", outs_now(), 7'b0001_0_1_0);

        apply("jz_after_rst", 4'b1100, 1'b1, 7'b0000_1_0_1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
